// File: rtl/dm_resp_pkg.sv
// Shared access-code definitions for the D-mem port, used by dm_resp and the
// CPU controller, plus small decode helpers for load/store misalignment.
package dm_resp_pkg;

  typedef enum logic [1:0] {
    MW_NONE = 2'b00,
    MW_SB   = 2'b01,
    MW_SH   = 2'b10,
    MW_SW   = 2'b11
  } mw_code_e;

  // 3'b110 and 3'b111 are reserved: they read as zero and never fault.
  typedef enum logic [2:0] {
    MR_NONE = 3'b000,
    MR_LB   = 3'b001,
    MR_LH   = 3'b010,
    MR_LW   = 3'b011,
    MR_LBU  = 3'b100,
    MR_LHU  = 3'b101
  } mr_code_e;

  // Cause bits are {out_of_range, misaligned}.
  typedef enum logic [1:0] {
    FC_NONE     = 2'b00,
    FC_MISALIGN = 2'b01,
    FC_OOR      = 2'b10,
    FC_BOTH     = 2'b11
  } fault_cause_e;

  function automatic logic is_load(input logic [2:0] mr);
    case (mr)
      MR_LB, MR_LH, MR_LW, MR_LBU, MR_LHU: return 1'b1;
      default:                             return 1'b0;
    endcase
  endfunction

  function automatic logic ld_misaligned(input logic [2:0] mr, input logic [1:0] lo);
    case (mr)
      MR_LH, MR_LHU: return lo[0];
      MR_LW:         return |lo;
      default:       return 1'b0;
    endcase
  endfunction

  function automatic logic st_misaligned(input logic [1:0] mw, input logic [1:0] lo);
    case (mw)
      MW_SH:   return lo[0];
      MW_SW:   return |lo;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dm_resp_if.sv
// D-mem port bundle between the core (master) and dm_resp (slave).
// DM_STATS_EN adds the ld_cnt/st_cnt statistics outputs.
interface dm_resp_if;
  logic [1:0]  MemWrite;
  logic [2:0]  MemRead;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        fault;
  logic [31:0] fault_addr;
  logic [1:0]  fault_cause;
`ifdef DM_STATS_EN
  logic [31:0] ld_cnt;
  logic [31:0] st_cnt;
`endif

  modport master (
    output MemWrite, MemRead, addr, writedata,
    input  readdata, fault, fault_addr, fault_cause
`ifdef DM_STATS_EN
    , input ld_cnt, st_cnt
`endif
  );

  modport slave (
    input  MemWrite, MemRead, addr, writedata,
    output readdata, fault, fault_addr, fault_cause
`ifdef DM_STATS_EN
    , output ld_cnt, st_cnt
`endif
  );
endinterface

// File: rtl/dm_resp_ldext.sv
// Load lane select and sign/zero extension of a raw 32-bit memory word.
module dm_resp_ldext
  import dm_resp_pkg::*;
(
  input  logic [2:0]  mem_read,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte/half, then extend according to the load code.
  always_comb begin
    byte_sel = word[7:0];
    case (lane)
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      2'd3:    byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    half_sel = lane[1] ? word[31:16] : word[15:0];
    data = '0;
    case (mem_read)
      MR_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      MR_LBU:  data = {24'd0, byte_sel};
      MR_LH:   data = {{16{half_sel[15]}}, half_sel};
      MR_LHU:  data = {16'd0, half_sel};
      MR_LW:   data = word;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/dm_resp.sv
// Data-memory responder: byte-lane stores into a word array, combinational
// extended loads, and a sticky first-fault record.
// Optional macro DM_STATS_EN: load/store statistics counters.
module dm_resp
  import dm_resp_pkg::*;
#(
  parameter int          ADDR_W = 7,
  parameter logic [31:0] BASE   = 32'h0000_0000
) (
  input  logic      clk,
  input  logic      rst,
  dm_resp_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0]       mem [DEPTH];
  logic [31:0]       off;
  logic [ADDR_W-1:0] idx;
  logic              oor;
  logic              ld_act, st_act, ld_mis, st_mis;
  logic              ld_ok, st_ok, any_fault;
  logic [3:0]        be;
  logic [31:0]       wlane, ld_word, ld_ext;

  // BASE is word aligned, so off[1:0] equals addr[1:0] for alignment checks.
  assign off       = bus.addr - BASE;
  assign oor       = |off[31:ADDR_W+2];
  assign idx       = off[ADDR_W+1:2];
  assign ld_act    = is_load(bus.MemRead);
  assign st_act    = (bus.MemWrite != MW_NONE);
  assign ld_mis    = ld_misaligned(bus.MemRead, off[1:0]);
  assign st_mis    = st_misaligned(bus.MemWrite, off[1:0]);
  assign ld_ok     = ld_act & ~ld_mis & ~oor;
  assign st_ok     = st_act & ~st_mis & ~oor;
  assign any_fault = (ld_act & ~ld_ok) | (st_act & ~st_ok);

  // Reads see pre-edge contents; a same-cycle store is not forwarded.
  assign ld_word = mem[idx];

  dm_resp_ldext u_ldext (
    .mem_read (bus.MemRead),
    .lane     (off[1:0]),
    .word     (ld_word),
    .data     (ld_ext)
  );

  assign bus.readdata = ld_ok ? ld_ext : '0;

  // Byte enables and lane-replicated store data for the addressed lanes.
  always_comb begin
    be    = 4'b0000;
    wlane = bus.writedata;
    case (bus.MemWrite)
      MW_SB: begin
        be    = 4'b0001 << off[1:0];
        wlane = {4{bus.writedata[7:0]}};
      end
      MW_SH: begin
        be    = off[1] ? 4'b1100 : 4'b0011;
        wlane = {2{bus.writedata[15:0]}};
      end
      MW_SW: begin
        be    = 4'b1111;
        wlane = bus.writedata;
      end
      default: begin
        be    = 4'b0000;
        wlane = bus.writedata;
      end
    endcase
  end

  // Word array; faulting stores are dropped entirely.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (st_ok) begin
      for (int l = 0; l < 4; l++)
        if (be[l]) mem[idx][8*l +: 8] <= wlane[8*l +: 8];
    end
  end

  // Sticky record of the first faulting access since reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.fault       <= 1'b0;
      bus.fault_addr  <= '0;
      bus.fault_cause <= FC_NONE;
    end else if (!bus.fault && any_fault) begin
      bus.fault       <= 1'b1;
      bus.fault_addr  <= bus.addr;
      bus.fault_cause <= {oor, ld_mis | st_mis};
    end
  end

`ifdef DM_STATS_EN
  // Count successful loads and committed stores; both wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.ld_cnt <= '0;
      bus.st_cnt <= '0;
    end else begin
      if (ld_ok) bus.ld_cnt <= bus.ld_cnt + 32'd1;
      if (st_ok) bus.st_cnt <= bus.st_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/dm_resp.md
Name: dm_resp

Overview:
- Data-memory responder on the CPU's D-mem port.
- Decodes the MemWrite/MemRead access codes and performs byte-lane stores into an internal word array.
- Returns sign- or zero-extended load data combinationally, in the same cycle as the request.
- Keeps a sticky fault record for misaligned or out-of-range accesses; sits between the core and the debug/top-level wrapper.

Parameters:
- ADDR_W, 7, log2 of array depth in 32-bit words (128 words = 512 B).
- BASE, 32'h0000_0000, byte address of word 0; must be 4-byte aligned.

Ports:
- clk  in  1  clock; stores commit on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- MemWrite  in  2  store code: 00 none, 01 SB, 10 SH, 11 SW.
- MemRead  in  3  load code: 000 none, 001 LB, 010 LH, 011 LW, 100 LBU, 101 LHU, 110/111 reserved.
- addr  in  32  byte address (CPU ALU output).
- writedata  in  32  store data; byte/half taken from the low bits.
- readdata  out  32  extended load data.
- fault  out  1  sticky: a faulting access occurred since reset.
- fault_addr  out  32  address of the first faulting access.
- fault_cause  out  2  01 misaligned, 10 out of range, 11 both on the first fault.

Behaviour:
- Address decode: off = addr - BASE. The access is in range iff off[31:ADDR_W+2] == 0. Word index = off[ADDR_W+1:2].
- Reset (rst low, asynchronous): all array words = 0, fault = 0, fault_addr = 0, fault_cause = 00.
- While in reset, readdata remains the combinational function of the (zeroed) array.
- Misalignment rules:
  - SH/LH/LHU misaligned iff addr[0] = 1.
  - SW/LW misaligned iff addr[1:0] != 00.
  - Byte accesses are never misaligned.
- Loads, zero-latency combinational:
  - LB selects byte addr[1:0] and sign-extends; LBU zero-extends.
  - LH selects half addr[1] and sign-extends; LHU zero-extends.
  - LW returns the whole word.
  - MemRead = 000, reserved, misaligned or out of range: readdata = 0.
- Stores: on a rising clk edge with MemWrite != 00, in range and aligned, write only the addressed lanes.
  - SB: lane addr[1:0] <- writedata[7:0].
  - SH: lanes {addr[1],0},{addr[1],1} <- writedata[15:0].
  - SW: all four lanes.
  - Other lanes hold their values.
- Faulting stores are fully suppressed; no partial write.
- Read/write collision (load and store codes both nonzero, same cycle): the store commits at the edge; readdata shows pre-edge contents. No forwarding.
- Fault capture:
  - A fault is any faulting load or store.
  - On the first one (fault = 0), at the clk edge: fault <- 1, fault_addr <- addr, fault_cause <- {oor, misaligned}.
  - Later faults do not update these registers. Only reset clears them.
  - Reserved MemRead codes do not fault.
- Reset deasserted mid-cycle: no store commits before the first rising edge with rst high.

Optional Feature:
- DM_STATS_EN defined: adds outputs ld_cnt[31:0] and st_cnt[31:0].
  - Each increments by 1 at every clk edge with a non-faulting load (resp. committed store).
  - Reset to 0; wrap 32'hFFFF_FFFF -> 0.
  - A collision cycle increments both.
- DM_STATS_EN undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Shared package/header: MemWrite codes (MW_NONE/SB/SH/SW), MemRead codes (MR_NONE/LB/LH/LW/LBU/LHU), fault cause codes. The CPU controller uses the same constants.
- One natural sub-module, dm_ldext: combinational lane select plus sign/zero extension from MemRead, addr[1:0] and the raw word.

Test Plan:
- Reset, then LW @0x10 -> readdata = 0; fault = 0, fault_cause = 00.
- SW 0x8765_4321 @0x10; LB @0x13 -> 0xFFFF_FF87; LBU @0x13 -> 0x0000_0087; LH @0x12 -> 0xFFFF_8765; LHU @0x10 -> 0x0000_4321.
- SW 0 @0x20, then SB 0xAB @0x21, then SH 0xCDEF @0x22; LW @0x20 -> 0xCDEF_AB00.
- SW 0x1111_1111 @0x22 (misaligned) -> word 0x20 unchanged, fault = 1, fault_addr = 0x22, fault_cause = 01. Then LW @0x400 (out of range, ADDR_W=7) -> readdata = 0 and fault_addr stays 0x22.
- Collision: word @0x30 = 0x5; same cycle LW @0x30 + SW 0x9 @0x30 -> readdata = 0x5 that cycle, 0x9 on the next LW.
- Assert rst low mid-run after the above stores -> all outputs and the array return to 0 immediately. With DM_STATS_EN: ld_cnt/st_cnt = 0, then count 3 loads, 2 stores -> 3/2.
